// File: rtl/periph_bus_pkg.sv
// Shared types for the peripheral bus master: FSM state encoding and phase counter width.
package periph_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_HIGH  = 2'd2,
      ST_HOLD  = 2'd3
   } bus_state_e;

   localparam int unsigned PHASE_CNT_W = 8;

endpackage

// File: rtl/periph_bus_master.sv
// Single-transaction master for a phi2-clocked peripheral register bus: request capture,
// address setup, phi2 high phase, then a hold cycle whose phi2 fall strobes writes.
module periph_bus_master
   import periph_bus_pkg::*;
#(
   parameter int unsigned HALF_CYCLES = 4
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_req_valid,
   output logic       o_req_ready,
   input  logic [1:0] i_req_addr,
   input  logic       i_req_rw,
   input  logic [7:0] i_req_wdata,
   output logic       o_rsp_valid,
   output logic [7:0] o_rsp_rdata,
   output logic       o_phi2,
   output logic [1:0] o_addr,
   output logic       o_rw,
   output logic       o_en,
   output logic [7:0] o_wdata,
   input  logic [7:0] i_rdata
);

   if (HALF_CYCLES < 2 || HALF_CYCLES > 255) begin : g_bad_half_cycles
      $error("periph_bus_master: HALF_CYCLES must be in 2..255");
   end

   localparam logic [PHASE_CNT_W-1:0] PHASE_RELOAD = PHASE_CNT_W'(HALF_CYCLES - 1);

   bus_state_e             state_q, state_d;
   logic [PHASE_CNT_W-1:0] cnt_q, cnt_d;
   logic                   ready_q, ready_d;
   logic                   phi2_q, phi2_d;
   logic                   en_q, en_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [7:0]             rsp_rdata_q, rsp_rdata_d;
   logic [1:0]             addr_q, addr_d;
   logic                   rw_q, rw_d;
   logic [7:0]             wdata_q, wdata_d;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         ready_q     <= 1'b1;
         phi2_q      <= 1'b0;
         en_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 8'h00;
         addr_q      <= 2'd0;
         rw_q        <= 1'b1;
         wdata_q     <= 8'h00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ready_q     <= ready_d;
         phi2_q      <= phi2_d;
         en_q        <= en_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         addr_q      <= addr_d;
         rw_q        <= rw_d;
         wdata_q     <= wdata_d;
      end
   end

   // Every output is registered, so each value is set one edge ahead of the cycle it appears in.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ready_d     = ready_q;
      phi2_d      = phi2_q;
      en_d        = en_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      addr_d      = addr_q;
      rw_d        = rw_q;
      wdata_d     = wdata_q;

      case (state_q)
         ST_IDLE: begin
            if (i_req_valid && ready_q) begin
               state_d = ST_SETUP;
               cnt_d   = PHASE_RELOAD;
               ready_d = 1'b0;
               en_d    = 1'b1;
               addr_d  = i_req_addr;
               rw_d    = i_req_rw;
               wdata_d = i_req_wdata;
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               state_d = ST_HIGH;
               cnt_d   = PHASE_RELOAD;
               phi2_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_HIGH: begin
            if (cnt_q == '0) begin
               state_d     = ST_HOLD;
               cnt_d       = '0;
               phi2_d      = 1'b0;
               rsp_valid_d = 1'b1;
               // Peripheral launched i_rdata on the rising phi2, so it is stable here.
               rsp_rdata_d = rw_q ? i_rdata : 8'h00;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_HOLD: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            en_d    = 1'b0;
            ready_d = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            phi2_d  = 1'b0;
            en_d    = 1'b0;
            ready_d = 1'b1;
         end
      endcase
   end

   assign o_req_ready = ready_q;
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_rdata = rsp_rdata_q;
   assign o_phi2      = phi2_q;
   assign o_en        = en_q;
   assign o_addr      = addr_q;
   assign o_rw        = rw_q;
   assign o_wdata     = wdata_q;

endmodule

// File: tb/tb_periph_bus_master.sv
// Bench for periph_bus_master: phi2-edge register model on the bus, table and random
// transactions checked against an array-based reference, plus reset and H=2 sequences.
module tb_periph_bus_master;

   localparam int H  = 4;
   localparam int H2 = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid, req_ready, req_rw, rsp_valid;
   logic [1:0] req_addr, bus_addr;
   logic [7:0] req_wdata, rsp_rdata, bus_wdata;
   logic       phi2, bus_rw, bus_en;
   logic [7:0] periph_rdata = 8'h00;

   logic       r2_valid, r2_ready, r2_rw, r2_rsp_valid;
   logic [1:0] r2_addr, b2_addr;
   logic [7:0] r2_wdata, r2_rsp_rdata, b2_wdata;
   logic       phi2_2, b2_rw, b2_en;
   logic [7:0] periph2_rdata = 8'h00;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   periph_bus_master #(.HALF_CYCLES(H)) dut (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_addr(req_addr), .i_req_rw(req_rw), .i_req_wdata(req_wdata),
      .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata),
      .o_phi2(phi2), .o_addr(bus_addr), .o_rw(bus_rw), .o_en(bus_en),
      .o_wdata(bus_wdata), .i_rdata(periph_rdata)
   );

   periph_bus_master #(.HALF_CYCLES(H2)) dut2 (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_req_valid(r2_valid), .o_req_ready(r2_ready),
      .i_req_addr(r2_addr), .i_req_rw(r2_rw), .i_req_wdata(r2_wdata),
      .o_rsp_valid(r2_rsp_valid), .o_rsp_rdata(r2_rsp_rdata),
      .o_phi2(phi2_2), .o_addr(b2_addr), .o_rw(b2_rw), .o_en(b2_en),
      .o_wdata(b2_wdata), .i_rdata(periph2_rdata)
   );

   // Peripheral register file: read data launched on rising phi2, write on falling phi2.
   logic [7:0] pregs [4] = '{8'h11, 8'h22, 8'h01, 8'h44};

   always @(posedge phi2) periph_rdata <= pregs[bus_addr];
   always @(negedge phi2) if (rst_n && bus_en && !bus_rw) pregs[bus_addr] <= bus_wdata;

   always @(posedge phi2_2) periph2_rdata <= 8'h3C ^ {6'd0, b2_addr};

   // Reference: a plain array of register contents updated once per completed transaction.
   logic [7:0] ref_mem [4];

   task automatic ref_access(input logic rw, input logic [1:0] a, input logic [7:0] wd,
                             output logic [7:0] exp_rd);
      if (rw) exp_rd = ref_mem[a];
      else begin
         ref_mem[a] = wd;
         exp_rd = 8'h00;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pack_pregs();
      return {pregs[3], pregs[2], pregs[1], pregs[0]};
   endfunction

   function automatic logic [31:0] pack_ref();
      return {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]};
   endfunction

   // Starts and ends at a falling clock edge with the master idle.
   task automatic run_txn(input logic rw, input logic [1:0] a, input logic [7:0] wd,
                          input bit scramble, output logic [7:0] got);
      logic [7:0]  exp_rd;
      logic        phi2_e, vld_e;
      logic [14:0] exp_v;
      req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = wd;
      chk("ready_before_accept", {31'd0, req_ready}, 32'd1);
      ref_access(rw, a, wd, exp_rd);
      got = 8'hxx;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int k = 1; k <= 2*H+1; k++) begin
         if (scramble && k == 3) begin
            req_valid = 1'b1; req_addr = 2'd3; req_wdata = 8'hFF; req_rw = ~rw;
         end
         if (k == 2*H+1) req_valid = 1'b0;
         @(negedge clk);
         phi2_e = (k > H) && (k <= 2*H);
         vld_e  = (k == 2*H+1);
         exp_v  = {1'b1, phi2_e, vld_e, 1'b0, a, rw, wd};
         chk($sformatf("txn_cycle_T%0d", k),
             {17'd0, bus_en, phi2, rsp_valid, req_ready, bus_addr, bus_rw, bus_wdata},
             {17'd0, exp_v});
         if (k == 2*H+1) begin
            got = rsp_rdata;
            chk("rsp_rdata_vs_ref", {24'd0, got}, {24'd0, exp_rd});
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("idle_after_txn", {28'd0, bus_en, phi2, rsp_valid, req_ready}, {28'd0, 4'b0001});
      chk("periph_regs_vs_ref", pack_pregs(), pack_ref());
   endtask

   typedef struct {
      logic       rw;
      logic [1:0] addr;
      logic [7:0] wdata;
      bit         scr;
      logic [7:0] exp_rd;
   } vec_t;

   vec_t tbl [6];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] got, e1, e2;
      int         n_gap;

      tbl[0] = '{1'b0, 2'd0, 8'h07, 1'b0, 8'h00};
      tbl[1] = '{1'b1, 2'd2, 8'h00, 1'b0, 8'h01};
      tbl[2] = '{1'b1, 2'd0, 8'h00, 1'b0, 8'h07};
      tbl[3] = '{1'b0, 2'd3, 8'h5A, 1'b1, 8'h00};
      tbl[4] = '{1'b1, 2'd3, 8'h00, 1'b0, 8'h5A};
      tbl[5] = '{1'b1, 2'd1, 8'h00, 1'b0, 8'h22};
      ref_mem = '{8'h11, 8'h22, 8'h01, 8'h44};

      rst_n = 1'b0;
      req_valid = 1'b0; req_rw = 1'b0; req_addr = 2'd0; req_wdata = 8'h00;
      r2_valid = 1'b0; r2_rw = 1'b0; r2_addr = 2'd0; r2_wdata = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs",
          {11'd0, req_ready, bus_en, phi2, rsp_valid, bus_addr, bus_rw, bus_wdata, rsp_rdata},
          {11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 8'h00, 8'h00});
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run_txn(tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].scr, got);
         chk($sformatf("table_rdata_%0d", i), {24'd0, got}, {24'd0, tbl[i].exp_rd});
      end

      // Back-to-back writes with i_req_valid held high.
      req_valid = 1'b1; req_rw = 1'b0; req_addr = 2'd1; req_wdata = 8'hA5;
      chk("queue_ready_first", {31'd0, req_ready}, 32'd1);
      ref_access(1'b0, 2'd1, 8'hA5, e1);
      ref_access(1'b0, 2'd2, 8'hC3, e2);
      @(posedge clk); #1;
      req_addr = 2'd2; req_wdata = 8'hC3;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         chk($sformatf("queue_ready_valid_T%0d", k), {30'd0, req_ready, rsp_valid},
             {30'd0, (k == 10), (k == 9)});
         if (k < 10) begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int j = 1; j <= 9; j++) begin
         @(negedge clk);
         chk($sformatf("queue_second_T%0d", j + 10),
             {20'd0, bus_en, rsp_valid, bus_addr, bus_wdata},
             {20'd0, 1'b1, (j == 9), 2'd2, 8'hC3});
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("queue_regs_vs_ref", pack_pregs(), pack_ref());

      for (int i = 0; i < 24; i++) begin
         logic       rw;
         logic [1:0] a;
         logic [7:0] wd;
         rw = 1'($urandom_range(0, 1));
         a  = 2'($urandom_range(0, 3));
         wd = 8'($urandom_range(0, 255));
         run_txn(rw, a, wd, ($urandom_range(0, 3) == 0), got);
         n_gap = $urandom_range(0, 2);
         repeat (n_gap) @(negedge clk);
      end

      // Reset during the high phase of a write abandons it.
      req_valid = 1'b1; req_rw = 1'b0; req_addr = 2'd0; req_wdata = 8'hEE;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      chk("abort_phi2_high_T6", {31'd0, phi2}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_reset_outputs",
          {11'd0, req_ready, bus_en, phi2, rsp_valid, bus_addr, bus_rw, bus_wdata, rsp_rdata},
          {11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 8'h00, 8'h00});
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         chk($sformatf("abort_after_release_%0d", k),
             {29'd0, req_ready, bus_en, rsp_valid}, {29'd0, 3'b100});
      end
      chk("abort_regs_unchanged", pack_pregs(), pack_ref());

      // HALF_CYCLES = 2 instance, read of address 1.
      r2_valid = 1'b1; r2_rw = 1'b1; r2_addr = 2'd1;
      chk("h2_ready_before", {31'd0, r2_ready}, 32'd1);
      @(posedge clk); #1;
      r2_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         chk($sformatf("h2_cycle_T%0d", k), {29'd0, phi2_2, r2_rsp_valid, b2_en},
             {29'd0, (k == 3 || k == 4), (k == 5), (k <= 5)});
         if (k == 5) chk("h2_rsp_rdata", {24'd0, r2_rsp_rdata}, 32'h3D);
         @(posedge clk); #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/periph_bus_master.md
PERIPH_BUS_MASTER -- requirements
Module: periph_bus_master

Interface
REQ-001 SHALL have parameter HALF_CYCLES, default 4, i_clk cycles per o_phi2 half-period (legal range 2..255).
REQ-002 SHALL have port i_clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port i_reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_req_valid  input  1  request present.
REQ-005 SHALL have port o_req_ready  output  1  block can accept a request.
REQ-006 SHALL have port i_req_addr  input  2  peripheral register address.
REQ-007 SHALL have port i_req_rw  input  1  1 = read, 0 = write.
REQ-008 SHALL have port i_req_wdata  input  8  write data.
REQ-009 SHALL have port o_rsp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port o_rsp_rdata  output  8  read data, qualified by o_rsp_valid.
REQ-011 SHALL have port o_phi2  output  1  gated bus clock to the peripheral.
REQ-012 SHALL have ports o_addr (2), o_rw (1), o_en (1), o_wdata (8)  outputs  peripheral register bus.
REQ-013 SHALL have port i_rdata  input  8  peripheral read data, registered by the peripheral on rising o_phi2.

Function
REQ-014 SHALL implement states IDLE, SETUP, HIGH, HOLD.
REQ-015 IDLE: o_req_ready = 1; handshake on i_req_valid && o_req_ready at a rising edge (T0) SHALL capture addr/rw/wdata into internal registers and enter SETUP.
REQ-016 Request inputs SHALL be ignored outside the accepting edge; o_addr/o_rw/o_wdata SHALL come only from captured registers.
REQ-017 SETUP (cycles T1..T_H, H = HALF_CYCLES): o_phi2 = 0, o_en = 1, bus outputs driven from captured values; then HIGH.
REQ-018 HIGH (cycles T_H+1..T_2H): o_phi2 = 1, bus outputs held; i_rdata SHALL be sampled into o_rsp_rdata at the edge ending T_2H when the request is a read.
REQ-019 HOLD (cycle T_2H+1): o_phi2 = 0 (falling edge = peripheral write strobe), o_en/o_addr/o_rw/o_wdata held, o_rsp_valid = 1; then IDLE.
REQ-020 In IDLE: o_phi2 = 0, o_en = 0; o_addr/o_rw/o_wdata retain last values; o_rsp_valid = 0.
REQ-021 For writes, o_rsp_rdata SHALL be 8'h00 during o_rsp_valid.
REQ-022 o_req_ready SHALL be 0 in SETUP, HIGH, HOLD; minimum request spacing 2H+2 cycles; next accept no earlier than T_2H+2.
REQ-023 Phase counter width SHALL be 8 bits; it SHALL reload at each state change, never wrap mid-phase.
REQ-024 All outputs SHALL be driven by flops (no combinational path input->output except none).
REQ-025 HALF_CYCLES < 2 SHALL fail elaboration via assertion.

Reset
REQ-026 Asserting i_reset_n low SHALL immediately force state IDLE, o_phi2 = 0, o_en = 0, o_rsp_valid = 0, o_addr = 0, o_rw = 1, o_wdata = 0, o_rsp_rdata = 0, counter = 0.
REQ-027 A transaction interrupted by reset SHALL be abandoned with no o_rsp_valid; o_req_ready = 1 on the first cycle after release.

Structure
REQ-028 State enum type SHALL live in shared package periph_bus_pkg; HALF_CYCLES stays a module parameter.
REQ-029 No sub-module; single module with FSM, phase counter, capture registers.

Verification (HALF_CYCLES = 4 unless stated; bench attaches a register model with phi2-edge read/write semantics)
REQ-030 Write addr 0 data 0x07 accepted at T0 -> o_en 1 T1..T9, o_phi2 1 T5..T8, model reg0 = 0x07 after T9, o_rsp_valid at T9, rdata 0x00.
REQ-031 Read addr 2, model returns 0x01 -> o_rsp_valid at T9 with o_rsp_rdata = 0x01, model state unchanged.
REQ-032 i_req_valid held high with two queued writes -> o_req_ready low T1..T9, second accepted at T10, second rsp at T19.
REQ-033 i_req_addr/i_req_wdata changed to 3/0xFF at T3 -> o_addr/o_wdata remain captured values through T9.
REQ-034 Reset pulsed at T6 of a write -> o_phi2, o_en, o_rsp_valid 0 immediately, no rsp, model register unchanged, o_req_ready 1 after release.
REQ-035 HALF_CYCLES = 2, read -> o_phi2 1 T3..T4, o_rsp_valid at T5.
